// File: rtl/sparc_memory_responder.sv
// Big-endian byte-addressed memory model answering the MOV/MOC handshake.
// A request is captured in IDLE, waits LATENCY edges in BUSY, then is
// completed in DONE until the processor drops MOV.
module sparc_memory_responder #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  Type,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Error
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Plain byte array, deliberately never reset.
    logic [7:0] mem [0:DEPTH-1];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  rw_q, rw_d;
    logic [1:0]            type_q, type_d;
    logic                  moc_q, moc_d;
    logic                  err_q, err_d;
    logic [31:0]           dout_q, dout_d;

    logic                  do_write;
    logic                  illegal;
    logic [31:0]           rdata;
    logic [ADDR_WIDTH-1:0] a1, a2, a3;

    // Only the low ADDR_WIDTH address bits are decoded; the rest alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[31:ADDR_WIDTH];

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign Error   = err_q;

    // Alignment check and big-endian read assembly from the latched request.
    always_comb begin
        a1 = addr_q + ADDR_WIDTH'(1);
        a2 = addr_q + ADDR_WIDTH'(2);
        a3 = addr_q + ADDR_WIDTH'(3);
        case (type_q)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = addr_q[0];
            2'b10:   illegal = |addr_q[1:0];
            default: illegal = 1'b1;
        endcase
        case (type_q)
            2'b00:   rdata = {24'b0, mem[addr_q]};
            2'b01:   rdata = {16'b0, mem[addr_q], mem[a1]};
            2'b10:   rdata = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
            default: rdata = '0;
        endcase
    end

    // Next-state logic for the handshake FSM and its output registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rw_d     = rw_q;
        type_d   = type_q;
        moc_d    = moc_q;
        err_d    = err_q;
        dout_d   = dout_q;
        do_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    addr_d  = Address[ADDR_WIDTH-1:0];
                    data_d  = DataIn;
                    rw_d    = RW;
                    type_d  = Type;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    moc_d   = 1'b1;
                    state_d = DONE;
                    if (illegal) begin
                        err_d  = 1'b1;
                        dout_d = '0;
                    end else if (rw_q) begin
                        err_d  = 1'b0;
                        dout_d = rdata;
                    end else begin
                        err_d    = 1'b0;
                        dout_d   = '0;
                        do_write = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!MOV) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; asynchronous reset aborts any access.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rw_q    <= 1'b0;
            type_q  <= '0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            type_q  <= type_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Big-endian byte-lane writes; aligned accesses never straddle the wrap.
    always_ff @(posedge Clk) begin
        if (do_write) begin
            case (type_q)
                2'b00: mem[addr_q] <= data_q[7:0];
                2'b01: begin
                    mem[addr_q] <= data_q[15:8];
                    mem[a1]     <= data_q[7:0];
                end
                2'b10: begin
                    mem[addr_q] <= data_q[31:24];
                    mem[a1]     <= data_q[23:16];
                    mem[a2]     <= data_q[15:8];
                    mem[a3]     <= data_q[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sparc_memory_responder.sv
// Bench for sparc_memory_responder: directed plan plus random transactions
// against a byte-array reference model.
module tb_sparc_memory_responder;

    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 1 << AW;

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;

    logic        MOV = 1'b0, RW = 1'b0;
    logic [1:0]  Type = '0;
    logic [31:0] Address = '0, DataIn = '0;
    logic [31:0] DataOut;
    logic        MOC, Error;

    logic        mov3 = 1'b0, rw3 = 1'b0;
    logic [1:0]  type3 = '0;
    logic [31:0] addr3 = '0, din3 = '0;
    logic [31:0] dout3;
    logic        moc3, err3;

    int unsigned passes = 0;
    int unsigned total  = 0;

    logic [7:0] ref_mem [DEPTH];

    always #5 Clk = ~Clk;

    sparc_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) dut2 (
        .Clk(Clk), .Clr(Clr), .MOV(MOV), .RW(RW), .Type(Type),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
        .MOC(MOC), .Error(Error)
    );

    sparc_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(3)) dut3 (
        .Clk(Clk), .Clr(Clr), .MOV(mov3), .RW(rw3), .Type(type3),
        .Address(addr3), .DataIn(din3), .DataOut(dout3),
        .MOC(moc3), .Error(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: access size in bytes, alignment by modulo, big-endian byte order.
    task automatic model(input bit rw, input logic [1:0] ty, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] expd, output bit experr);
        int unsigned size;
        int unsigned base;
        size   = 1 << ty;
        base   = a % DEPTH;
        experr = (ty == 2'b11) || (base % size != 0);
        expd   = '0;
        if (!experr) begin
            for (int unsigned i = 0; i < size; i++) begin
                if (rw) expd = (expd << 8) | 32'(ref_mem[base + i]);
                else    ref_mem[base + i] = 8'(d >> (8 * (size - 1 - i)));
            end
        end
    endtask

    task automatic txn(input bit rw, input logic [1:0] ty, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
        logic [31:0] expd;
        bit          experr;
        int unsigned edges;
        bit          got;
        model(rw, ty, a, d, expd, experr);
        @(negedge Clk);
        MOV = 1'b1; RW = rw; Type = ty; Address = a; DataIn = d;
        @(posedge Clk);
        #1;
        Address = $urandom; DataIn = $urandom; Type = 2'($urandom);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            @(posedge Clk);
            #1;
            edges++;
            if (MOC === 1'b1) got = 1'b1;
        end
        chk({tag, "_lat"}, 32'(edges), 32'd2);
        chk({tag, "_err"}, {31'b0, Error}, {31'b0, experr});
        chk({tag, "_data"}, DataOut, expd);
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk);
        #1;
        chk({tag, "_mocclr"}, {31'b0, MOC}, 32'd0);
        chk({tag, "_errclr"}, {31'b0, Error}, 32'd0);
        chk({tag, "_hold"}, DataOut, expd);
    endtask

    initial begin
        logic [1:0]  ty;
        logic [31:0] a;

        // Reset state.
        @(posedge Clk);
        #1;
        chk("rst_moc", {31'b0, MOC}, 32'd0);
        chk("rst_err", {31'b0, Error}, 32'd0);
        chk("rst_dout", DataOut, 32'd0);
        chk("rst_moc3", {31'b0, moc3}, 32'd0);
        @(negedge Clk);
        Clr = 1'b0;

        // Fill the whole array through the bus so the model knows every byte.
        for (int unsigned i = 0; i < DEPTH / 4; i++)
            txn(1'b0, 2'b10, 32'(i * 4), $urandom, "preload");

        // Word round trip and sub-word accesses.
        txn(1'b0, 2'b10, 32'h010, 32'hDEADBEEF, "w_word");
        txn(1'b1, 2'b10, 32'h010, 32'h0, "r_word");
        chk("lit_word", DataOut, 32'hDEADBEEF);
        txn(1'b1, 2'b00, 32'h011, 32'h0, "r_byte");
        chk("lit_byte", DataOut, 32'h000000AD);
        txn(1'b1, 2'b01, 32'h012, 32'h0, "r_half");
        chk("lit_half", DataOut, 32'h0000BEEF);
        txn(1'b0, 2'b00, 32'h013, 32'h12345677, "w_byte");
        txn(1'b1, 2'b10, 32'h010, 32'h0, "r_word2");
        chk("lit_word2", DataOut, 32'hDEADBE77);

        // Illegal requests.
        txn(1'b0, 2'b10, 32'h012, 32'hFFFFFFFF, "w_misal");
        txn(1'b1, 2'b10, 32'h010, 32'h0, "r_after_misal");
        chk("lit_after_misal", DataOut, 32'hDEADBE77);
        txn(1'b1, 2'b11, 32'h000, 32'h0, "r_type3");
        txn(1'b1, 2'b01, 32'h001, 32'h0, "r_half_misal");

        // Aliasing above the decoded address bits.
        txn(1'b0, 2'b10, 32'h00000210, 32'hCAFEF00D, "w_alias");
        txn(1'b1, 2'b10, 32'h00000010, 32'h0, "r_alias");
        chk("lit_alias", DataOut, 32'hCAFEF00D);

        // Clr during BUSY aborts the write.
        @(negedge Clk);
        MOV = 1'b1; RW = 1'b0; Type = 2'b10; Address = 32'h020; DataIn = 32'h11111111;
        @(posedge Clk);
        @(negedge Clk);
        Clr = 1'b1;
        #1;
        chk("abort_moc_async", {31'b0, MOC}, 32'd0);
        MOV = 1'b0;
        repeat (2) begin
            @(posedge Clk);
            #1;
            chk("abort_moc", {31'b0, MOC}, 32'd0);
        end
        @(negedge Clk);
        Clr = 1'b0;
        repeat (3) begin
            @(posedge Clk);
            #1;
            chk("abort_idle_moc", {31'b0, MOC}, 32'd0);
        end
        chk("abort_dout", DataOut, 32'd0);
        txn(1'b1, 2'b10, 32'h020, 32'h0, "r_after_abort");

        // Clr in DONE drops MOC without a clock edge.
        @(negedge Clk);
        MOV = 1'b1; RW = 1'b1; Type = 2'b10; Address = 32'h010;
        repeat (3) @(posedge Clk);
        #1;
        chk("done_moc", {31'b0, MOC}, 32'd1);
        @(negedge Clk);
        Clr = 1'b1;
        #1;
        chk("done_clr_moc", {31'b0, MOC}, 32'd0);
        chk("done_clr_dout", DataOut, 32'd0);
        MOV = 1'b0;
        @(negedge Clk);
        Clr = 1'b0;

        // LATENCY=3 handshake with MOV held for six edges.
        @(negedge Clk);
        mov3 = 1'b1; rw3 = 1'b0; type3 = 2'b10; addr3 = 32'h040; din3 = $urandom;
        for (int e = 0; e < 6; e++) begin
            @(posedge Clk);
            #1;
            chk("hold_moc3", {31'b0, moc3}, {31'b0, (e >= 3)});
        end
        @(negedge Clk);
        mov3 = 1'b0;
        for (int e = 0; e < 3; e++) begin
            @(posedge Clk);
            #1;
            chk("hold_clr3", {31'b0, moc3}, 32'd0);
        end

        // LATENCY=3 with a one-cycle MOV pulse.
        @(negedge Clk);
        mov3 = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        mov3 = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge Clk);
            #1;
            chk("pulse_moc3", {31'b0, moc3}, {31'b0, (e == 3)});
        end

        // Random transactions, mostly aligned.
        for (int n = 0; n < 80; n++) begin
            ty = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (ty != 2'b11 && $urandom_range(0, 3) != 0)
                a = a & ~((32'd1 << ty) - 32'd1);
            txn(1'($urandom), ty, a, $urandom, "rand");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
